nf_imem_arb: RTL and testbench

Arbiter and halt sequencer for the single-port instruction memory shared by the CPU fetch path and the debug/program loader. Grants at most one memory access per cycle, steers the 1-cycle-latency read data back to the owner, and provides a halt handshake so the loader can freeze the CPU and own the memory for reprogramming. Sits between the CPU fetch port (`instr_addr`/`instr`) and the instruction RAM; `cpu_hold` gates the CPU's PC/register-file write enable.

---
 rtl/nf_imem_arb_if.sv | 43 ++++
 rtl/nf_imem_arb.sv | 102 ++++++++++
 tb/tb_nf_imem_arb.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/nf_imem_arb_if.sv
// Bundle of CPU fetch, loader and instruction-RAM signals around nf_imem_arb.
// slave = arbiter view, master = requesters plus memory.
interface nf_imem_arb_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();
   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_hold;

   logic              ld_req;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_gnt;
   logic              ld_rvalid;
   logic [DATA_W-1:0] ld_rdata;
   logic              ld_halt_req;
   logic              ld_halt_ack;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_halt_req, mem_rdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_hold,
      output ld_gnt, ld_rvalid, ld_rdata, ld_halt_ack,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req, cpu_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_halt_req, mem_rdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_hold,
      input  ld_gnt, ld_rvalid, ld_rdata, ld_halt_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/nf_imem_arb.sv
// Instruction-memory arbiter and CPU halt sequencer (CPU fetch vs. debug loader).
// Define NF_IMEM_ARB_STARVE_EN to add the CPU starvation counter / forced grant.
module nf_imem_arb #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 8
) (
   input logic          clk,
   input logic          reset,
   nf_imem_arb_if.slave bus
);
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t            state_q, state_d;
   logic              cpu_gnt, ld_gnt, cpu_hold, starve_hit;
   logic              cpu_rvalid_q, ld_rvalid_q, ld_halt_ack_q;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] rdata;

`ifdef NF_IMEM_ARB_STARVE_EN
   logic [7:0] starve_q;

   always_ff @(posedge clk) begin
      if (reset)
         starve_q <= '0;
      else if (!bus.cpu_req || cpu_gnt)
         starve_q <= '0;
      else if (starve_q != 8'(STARVE_MAX))
         starve_q <= starve_q + 8'd1;
   end

   assign starve_hit = (starve_q == 8'(STARVE_MAX));
`else
   assign starve_hit = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   // A CPU read still returning blocks entry to HALTED; RUN never grants the CPU
   // while halting, so DRAIN normally lasts a single cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (bus.ld_halt_req) state_d = DRAIN;
         DRAIN: begin
            if (!bus.ld_halt_req)   state_d = RUN;
            else if (!cpu_rvalid_q) state_d = HALTED;
         end
         HALTED:  if (!bus.ld_halt_req) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cpu_gnt = 1'b0;
      ld_gnt  = 1'b0;
      case (state_q)
         RUN: begin
            ld_gnt  = bus.ld_req & ~(bus.cpu_req & starve_hit & ~bus.ld_halt_req);
            cpu_gnt = bus.cpu_req & ~ld_gnt & ~bus.ld_halt_req;
         end
         default: ld_gnt = bus.ld_req;
      endcase
      cpu_hold = (state_q != RUN) | (bus.cpu_req & ~cpu_gnt);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_rvalid_q  <= 1'b0;
         ld_rvalid_q   <= 1'b0;
         ld_halt_ack_q <= 1'b0;
      end else begin
         cpu_rvalid_q  <= cpu_gnt;
         ld_rvalid_q   <= ld_gnt & ~bus.ld_we;
         ld_halt_ack_q <= (state_d == HALTED);
      end
   end

   assign addr_mux = ld_gnt ? bus.ld_addr : bus.cpu_addr;
   assign rdata    = bus.mem_rdata;

   assign bus.mem_en      = cpu_gnt | ld_gnt;
   assign bus.mem_we      = ld_gnt & bus.ld_we;
   assign bus.mem_addr    = addr_mux;
   assign bus.mem_wdata   = bus.ld_wdata;

   assign bus.cpu_gnt     = cpu_gnt;
   assign bus.cpu_hold    = cpu_hold;
   assign bus.cpu_rvalid  = cpu_rvalid_q;
   assign bus.cpu_rdata   = rdata;
   assign bus.ld_gnt      = ld_gnt;
   assign bus.ld_rvalid   = ld_rvalid_q;
   assign bus.ld_rdata    = rdata;
   assign bus.ld_halt_ack = ld_halt_ack_q;
endmodule

// File: tb/tb_nf_imem_arb.sv
// Directed bench for nf_imem_arb with a 64-word behavioural RAM (word at A is 0xC0DE0000|A).
module tb_nf_imem_arb;
   logic clk;
   logic reset;
   int   compared   = 0;
   int   mismatched = 0;
   logic exp_cpu;
   logic [31:0] ram [64];

   nf_imem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   nf_imem_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
         else            bus.mem_rdata <= ram[bus.mem_addr[7:2]];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = 32'hC0DE_0000 | 32'(i << 2);
      reset = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_addr = '0;
      bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
      bus.ld_halt_req = 1'b0; bus.mem_rdata = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
      check("rst_ld_rvalid", 32'(bus.ld_rvalid), 0);
      check("rst_halt_ack", 32'(bus.ld_halt_ack), 0);
      check("rst_cpu_hold", 32'(bus.cpu_hold), 0);
      check("rst_mem_en", 32'(bus.mem_en), 0);

      // CPU-only back-to-back fetches
      bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0; #1;
      check("c0_gnt", 32'(bus.cpu_gnt), 1);
      check("c0_hold", 32'(bus.cpu_hold), 0);
      check("c0_mem_addr", bus.mem_addr, 32'h0);
      check("c0_mem_we", 32'(bus.mem_we), 0);
      tick();
      bus.cpu_addr = 32'h4; #1;
      check("c1_gnt", 32'(bus.cpu_gnt), 1);
      check("c1_rvalid", 32'(bus.cpu_rvalid), 1);
      check("c1_rdata", bus.cpu_rdata, 32'hC0DE_0000);
      tick();
      bus.cpu_addr = 32'h8; #1;
      check("c2_gnt", 32'(bus.cpu_gnt), 1);
      check("c2_rdata", bus.cpu_rdata, 32'hC0DE_0004);
      check("c2_hold", 32'(bus.cpu_hold), 0);
      tick();
      bus.cpu_req = 1'b0; #1;
      check("c3_rvalid", 32'(bus.cpu_rvalid), 1);
      check("c3_rdata", bus.cpu_rdata, 32'hC0DE_0008);
      check("c3_gnt", 32'(bus.cpu_gnt), 0);
      tick();
      check("c4_rvalid", 32'(bus.cpu_rvalid), 0);

      // Continuous contention: loader priority, optional forced CPU grant every 9th cycle
      bus.cpu_req = 1'b1; bus.cpu_addr = 32'h40;
      bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h44;
      for (int i = 0; i < 17; i++) begin
         #1;
`ifdef NF_IMEM_ARB_STARVE_EN
         exp_cpu = (i % 9 == 8);
`else
         exp_cpu = 1'b0;
`endif
         check($sformatf("cont%0d_cpu_gnt", i), 32'(bus.cpu_gnt), 32'(exp_cpu));
         check($sformatf("cont%0d_ld_gnt", i), 32'(bus.ld_gnt), 32'(!exp_cpu));
         check($sformatf("cont%0d_hold", i), 32'(bus.cpu_hold), 32'(!exp_cpu));
         tick();
      end
      bus.cpu_req = 1'b0; bus.ld_req = 1'b0; #1;
      check("cont_ld_rvalid", 32'(bus.ld_rvalid), 1);
      check("cont_ld_rdata", bus.ld_rdata, 32'hC0DE_0044);
      check("cont_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
      tick();

      // Halt handshake with a CPU read in flight
      bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10; #1;
      check("h0_cpu_gnt", 32'(bus.cpu_gnt), 1);
      tick();
      bus.cpu_req = 1'b0; bus.ld_halt_req = 1'b1; #1;
      check("h1_cpu_rvalid", 32'(bus.cpu_rvalid), 1);
      check("h1_cpu_rdata", bus.cpu_rdata, 32'hC0DE_0010);
      check("h1_ack", 32'(bus.ld_halt_ack), 0);
      tick();
      bus.cpu_req = 1'b1; bus.cpu_addr = 32'h30; #1;
      check("drain_ack", 32'(bus.ld_halt_ack), 0);
      check("drain_cpu_gnt", 32'(bus.cpu_gnt), 0);
      check("drain_hold", 32'(bus.cpu_hold), 1);
      tick();
      bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h20; bus.ld_wdata = 32'hDEAD_BEEF; #1;
      check("halt_ack", 32'(bus.ld_halt_ack), 1);
      check("halt_wr_gnt", 32'(bus.ld_gnt), 1);
      check("halt_cpu_gnt", 32'(bus.cpu_gnt), 0);
      check("halt_mem_we", 32'(bus.mem_we), 1);
      check("halt_mem_addr", bus.mem_addr, 32'h20);
      check("halt_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      tick();
      bus.ld_we = 1'b0; #1;
      check("halt_rd_gnt", 32'(bus.ld_gnt), 1);
      check("halt_rd_mem_we", 32'(bus.mem_we), 0);
      check("halt_wr_no_rvalid", 32'(bus.ld_rvalid), 0);
      tick();
      bus.ld_req = 1'b0; bus.ld_halt_req = 1'b0; #1;
      check("halt_ld_rvalid", 32'(bus.ld_rvalid), 1);
      check("halt_ld_rdata", bus.ld_rdata, 32'hDEAD_BEEF);
      check("halt_cpu_gnt2", 32'(bus.cpu_gnt), 0);
      check("halt_ack2", 32'(bus.ld_halt_ack), 1);
      tick();
      check("resume_ack", 32'(bus.ld_halt_ack), 0);
      check("resume_cpu_gnt", 32'(bus.cpu_gnt), 1);
      check("resume_hold", 32'(bus.cpu_hold), 0);
      check("resume_mem_addr", bus.mem_addr, 32'h30);
      tick();
      bus.cpu_req = 1'b0; #1;
      check("resume_rdata", bus.cpu_rdata, 32'hC0DE_0030);
      check("resume_rvalid", 32'(bus.cpu_rvalid), 1);

      // Reset while a loader read is being granted in HALTED
      bus.ld_halt_req = 1'b1;
      tick(); tick();
      check("r_halt_ack", 32'(bus.ld_halt_ack), 1);
      bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h8; reset = 1'b1; #1;
      check("r_ld_gnt", 32'(bus.ld_gnt), 1);
      tick();
      reset = 1'b0; bus.ld_req = 1'b0; #1;
      check("r_ld_rvalid", 32'(bus.ld_rvalid), 0);
      check("r_ack", 32'(bus.ld_halt_ack), 0);
      check("r_hold_run", 32'(bus.cpu_hold), 0);
      bus.ld_halt_req = 1'b0; bus.cpu_req = 1'b1; bus.cpu_addr = 32'hC; bus.ld_req = 1'b1; #1;
      check("r_ld_priority", 32'(bus.ld_gnt), 1);
      check("r_cpu_denied", 32'(bus.cpu_gnt), 0);
      tick();
      bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
